boot_mem_sequencer: RTL and testbench

Boot-time owner of the processor's single unified memory port. After reset it holds the `mips` core in reset, streams a byte-serial program image into memory as 32-bit words, then releases the core and hands it the port. It sits between the `mips` top, the instruction/data memory and a host-side byte source such as a UART receiver.

---
 rtl/boot_mem_sequencer_if.sv | 34 +++
 rtl/boot_mem_sequencer.sv | 127 ++++++++++++
 tb/tb_boot_mem_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_mem_sequencer_if.sv
// Bundle of the loader byte stream, core-side memory bus and memory-side port
// seen by boot_mem_sequencer.
interface boot_mem_sequencer_if;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic        cpu_reset;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_writedata;
    logic        cpu_memwrite;
    logic [31:0] cpu_readdata;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last,
        input  cpu_adr, cpu_writedata, cpu_memwrite, mem_rd,
        output ld_ready, ld_done, ld_err, cpu_reset, cpu_readdata,
        output mem_adr, mem_wd, mem_we
    );

    modport master (
        output ld_start, ld_valid, ld_byte, ld_last,
        output cpu_adr, cpu_writedata, cpu_memwrite, mem_rd,
        input  ld_ready, ld_done, ld_err, cpu_reset, cpu_readdata,
        input  mem_adr, mem_wd, mem_we
    );
endinterface

// File: rtl/boot_mem_sequencer.sv
// Boot-time owner of the unified memory port: holds the core in reset, loads a
// big-endian byte-serial image as 32-bit words, then hands the port to the core.
module boot_mem_sequencer #(
    parameter int unsigned DEPTH = 64
) (
    input logic                  clk,
    input logic                  reset,
    boot_mem_sequencer_if.slave  bus
);

    localparam int unsigned WidxW = $clog2(DEPTH + 1);
    localparam logic [WidxW-1:0] WidxMax = WidxW'(DEPTH);

    localparam logic [2:0] StHold    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StWrite   = 3'd2;
    localparam logic [2:0] StRelease = 3'd3;
    localparam logic [2:0] StRun     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WidxW-1:0] widx_q, widx_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [31:0]      asm_q, asm_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             ready_q, cpu_reset_q, done_q;

    logic byte_acc;
    assign byte_acc = (state_q == StLoad) && bus.ld_valid && ready_q;

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            StLoad: begin
                if (byte_acc) begin
                    unique case (bcnt_q[1:0])
                        2'd0: asm_d[31:24] = bus.ld_byte;
                        2'd1: asm_d[23:16] = bus.ld_byte;
                        2'd2: asm_d[15:8]  = bus.ld_byte;
                        2'd3: asm_d[7:0]   = bus.ld_byte;
                    endcase
                    bcnt_d = bcnt_q + 3'd1;
                    if (bus.ld_last || (bcnt_q == 3'd3)) begin
                        state_d = StWrite;
                        last_d  = bus.ld_last;
                    end
                end
            end
            StWrite: begin
                if (widx_q == WidxMax) err_d = 1'b1;
                else                   widx_d = widx_q + WidxW'(1);
                bcnt_d  = 3'd0;
                asm_d   = 32'd0;
                last_d  = 1'b0;
                state_d = last_q ? StRelease : StLoad;
            end
            StRelease: state_d = StRun;
            StRun:     state_d = StRun;
            StHold:    state_d = StHold;
            default:   state_d = StHold;
        endcase
        // A (re)start overrides any byte or word completion in the same cycle.
        if (bus.ld_start && (state_q != StRelease)) begin
            state_d = StLoad;
            widx_d  = '0;
            bcnt_d  = 3'd0;
            asm_d   = 32'd0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHold;
            widx_q      <= '0;
            bcnt_q      <= 3'd0;
            asm_q       <= 32'd0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            last_q      <= last_d;
            err_q       <= err_d;
            ready_q     <= (state_d == StLoad);
            cpu_reset_q <= (state_d != StRun);
            done_q      <= (state_d == StRelease);
        end
    end

    always_comb begin
        bus.mem_we  = 1'b0;
        bus.mem_adr = 32'd0;
        bus.mem_wd  = 32'd0;
        case (state_q)
            StWrite: begin
                bus.mem_we  = (widx_q != WidxMax);
                bus.mem_adr = 32'({widx_q, 2'b00});
                bus.mem_wd  = asm_q;
            end
            StRun: begin
                bus.mem_we  = bus.cpu_memwrite;
                bus.mem_adr = bus.cpu_adr;
                bus.mem_wd  = bus.cpu_writedata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_readdata = bus.mem_rd;
    assign bus.ld_ready     = ready_q;
    assign bus.ld_done      = done_q;
    assign bus.ld_err       = err_q;
    assign bus.cpu_reset    = cpu_reset_q;

endmodule

// File: tb/tb_boot_mem_sequencer.sv
// Drives a DEPTH=64 and a DEPTH=2 sequencer with identical stimulus and checks
// each against a word-level model of the loaded image.
module tb_boot_mem_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, cpu_memwrite = 1'b0;
    logic [7:0] ld_byte = 8'd0;
    logic [31:0] cpu_adr = 32'd0, cpu_writedata = 32'd0, mem_rd = 32'd0;

    always #5 clk = ~clk;

    boot_mem_sequencer_if if_big ();
    boot_mem_sequencer_if if_small ();

    assign if_big.ld_start      = ld_start;
    assign if_big.ld_valid      = ld_valid;
    assign if_big.ld_byte       = ld_byte;
    assign if_big.ld_last       = ld_last;
    assign if_big.cpu_adr       = cpu_adr;
    assign if_big.cpu_writedata = cpu_writedata;
    assign if_big.cpu_memwrite  = cpu_memwrite;
    assign if_big.mem_rd        = mem_rd;
    assign if_small.ld_start      = ld_start;
    assign if_small.ld_valid      = ld_valid;
    assign if_small.ld_byte       = ld_byte;
    assign if_small.ld_last       = ld_last;
    assign if_small.cpu_adr       = cpu_adr;
    assign if_small.cpu_writedata = cpu_writedata;
    assign if_small.cpu_memwrite  = cpu_memwrite;
    assign if_small.mem_rd        = mem_rd;

    boot_mem_sequencer #(.DEPTH(64)) u_big (.clk(clk), .reset(reset), .bus(if_big));
    boot_mem_sequencer #(.DEPTH(2)) u_small (.clk(clk), .reset(reset), .bus(if_small));

    int errors = 0;
    int checks = 0;

    logic [31:0] big_adr[$], big_wd[$], small_adr[$], small_wd[$];
    int big_done = 0, small_done = 0;
    logic [7:0] img[$];
    logic [31:0] words[$];

    always @(negedge clk) begin
        if (if_big.mem_we) begin
            big_adr.push_back(if_big.mem_adr);
            big_wd.push_back(if_big.mem_wd);
        end
        if (if_small.mem_we) begin
            small_adr.push_back(if_small.mem_adr);
            small_wd.push_back(if_small.mem_wd);
        end
        if (if_big.ld_done) big_done++;
        if (if_small.ld_done) small_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        big_adr.delete(); big_wd.delete(); small_adr.delete(); small_wd.delete();
        big_done = 0;
        small_done = 0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            repeat ($urandom_range(0, 2)) step();
            ld_valid = 1'b1;
            ld_byte  = img[i];
            ld_last  = last_on_final && (i == n - 1);
            while (!if_big.ld_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) begin
                checks++;
                errors++;
                $display("FAIL byte_accept: ld_ready=%0b after %0d cycles, required 1",
                         if_big.ld_ready, guard);
            end
            step();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!if_big.ld_done && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (if_big.ld_done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: ld_done=%0b, required 1 within 20 cycles",
                     if_big.ld_done);
        end
    endtask

    task automatic do_load();
        clear_logs();
        pulse_start();
        send_bytes(img.size(), 1'b1);
        wait_done();
    endtask

    // Expected words: consecutive groups of four bytes, first byte most
    // significant, missing bytes of the final group read as zero.
    function automatic void build_words();
        logic [31:0] w;
        words.delete();
        for (int i = 0; i < img.size(); i += 4) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++)
                if (i + j < img.size()) w = w | (32'(img[i+j]) << (24 - 8 * j));
            words.push_back(w);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cpu_memwrite = 1'b1;
        cpu_adr = 32'h54;
        step();
        step();
        checks++; if (if_big.cpu_reset !== 1'b1) begin errors++;
            $display("FAIL reset_cpu_reset: got %0b want 1", if_big.cpu_reset); end
        checks++; if (if_big.ld_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ld_ready: got %0b want 0", if_big.ld_ready); end
        checks++; if (if_big.ld_done !== 1'b0) begin errors++;
            $display("FAIL reset_ld_done: got %0b want 0", if_big.ld_done); end
        checks++; if (if_big.ld_err !== 1'b0 || if_small.ld_err !== 1'b0) begin errors++;
            $display("FAIL reset_ld_err: got %0b/%0b want 0/0", if_big.ld_err, if_small.ld_err); end
        checks++; if (if_big.mem_we !== 1'b0) begin errors++;
            $display("FAIL reset_mem_we: got %0b want 0", if_big.mem_we); end
        checks++; if (if_big.mem_adr !== 32'd0) begin errors++;
            $display("FAIL reset_mem_adr: got %0h want 0", if_big.mem_adr); end
        reset = 1'b0;
        cpu_memwrite = 1'b0;
        step();
        checks++; if (if_big.ld_ready !== 1'b0 || if_big.cpu_reset !== 1'b1) begin errors++;
            $display("FAIL hold_idle: ready=%0b cpu_reset=%0b want 0/1",
                     if_big.ld_ready, if_big.cpu_reset); end
    endtask

    task automatic test_fixed_image();
        img = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
        do_load();
        checks++; if (if_big.cpu_reset !== 1'b1) begin errors++;
            $display("FAIL fixed_cpu_reset_at_done: got %0b want 1", if_big.cpu_reset); end
        checks++;
        if (big_adr.size() != 2) begin errors++;
            $display("FAIL fixed_write_count: got %0d want 2", big_adr.size());
        end else if (big_adr[0] !== 32'h0 || big_wd[0] !== 32'h20020005 ||
                     big_adr[1] !== 32'h4 || big_wd[1] !== 32'h2003000C) begin
            errors++;
            $display("FAIL fixed_writes: got %0h:%0h %0h:%0h want 0:20020005 4:2003000c",
                     big_adr[0], big_wd[0], big_adr[1], big_wd[1]);
        end
        checks++; if (small_adr.size() != 2 || if_small.ld_err !== 1'b0) begin errors++;
            $display("FAIL fixed_small: writes=%0d err=%0b want 2/0",
                     small_adr.size(), if_small.ld_err); end
        step();
        checks++; if (if_big.cpu_reset !== 1'b0 || if_big.ld_done !== 1'b0) begin errors++;
            $display("FAIL fixed_release: cpu_reset=%0b done=%0b want 0/0",
                     if_big.cpu_reset, if_big.ld_done); end
        checks++; if (big_done != 1) begin errors++;
            $display("FAIL fixed_done_pulses: got %0d want 1", big_done); end
    endtask

    task automatic test_partial_word();
        img.delete();
        for (int i = 0; i < 5; i++) img.push_back(8'($urandom));
        img.push_back(8'hAB);
        do_load();
        step();
        checks++;
        if (big_adr.size() != 2) begin errors++;
            $display("FAIL partial_write_count: got %0d want 2", big_adr.size());
        end else if (big_adr[1] !== 32'h4 || big_wd[1] !== {img[4], 8'hAB, 16'h0}) begin
            errors++;
            $display("FAIL partial_tail: got %0h:%0h want 4:%0h", big_adr[1], big_wd[1],
                     {img[4], 8'hAB, 16'h0});
        end
        checks++;
        if (big_wd.size() > 0 && big_wd[0] !== {img[0], img[1], img[2], img[3]}) begin
            errors++;
            $display("FAIL partial_head: got %0h want %0h", big_wd[0],
                     {img[0], img[1], img[2], img[3]});
        end
    endtask

    task automatic test_overflow();
        img.delete();
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        do_load();
        step();
        checks++; if (small_adr.size() != 2) begin errors++;
            $display("FAIL overflow_write_count: got %0d want 2", small_adr.size()); end
        checks++; if (if_small.ld_err !== 1'b1 || if_big.ld_err !== 1'b0) begin errors++;
            $display("FAIL overflow_err: small=%0b big=%0b want 1/0",
                     if_small.ld_err, if_big.ld_err); end
        checks++; if (if_small.cpu_reset !== 1'b0 || small_done != 1) begin errors++;
            $display("FAIL overflow_release: cpu_reset=%0b done=%0d want 0/1",
                     if_small.cpu_reset, small_done); end
        checks++; if (big_adr.size() != 3) begin errors++;
            $display("FAIL overflow_big_writes: got %0d want 3", big_adr.size()); end
        pulse_start();
        checks++; if (if_small.ld_err !== 1'b0 || if_small.cpu_reset !== 1'b1) begin errors++;
            $display("FAIL overflow_clear: err=%0b cpu_reset=%0b want 0/1",
                     if_small.ld_err, if_small.cpu_reset); end
    endtask

    task automatic test_random_images();
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 14);
            int nsmall;
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            build_words();
            nsmall = (words.size() > 2) ? 2 : words.size();
            do_load();
            step();
            checks++;
            if (big_adr.size() != words.size() || small_adr.size() != nsmall) begin errors++;
                $display("FAIL rand_counts: big=%0d small=%0d want %0d/%0d",
                         big_adr.size(), small_adr.size(), words.size(), nsmall);
            end else begin
                for (int i = 0; i < words.size(); i++) begin
                    checks++;
                    if (big_adr[i] !== 32'(i * 4) || big_wd[i] !== words[i] ||
                        (i < nsmall && small_wd[i] !== words[i])) begin errors++;
                        $display("FAIL rand_word%0d: got %0h:%0h want %0h:%0h", i,
                                 big_adr[i], big_wd[i], i * 4, words[i]);
                    end
                end
            end
            checks++;
            if (if_small.ld_err !== (words.size() > 2) || if_big.ld_err !== 1'b0) begin
                errors++;
                $display("FAIL rand_err: small=%0b big=%0b want %0b/0", if_small.ld_err,
                         if_big.ld_err, words.size() > 2);
            end
        end
    endtask

    task automatic test_run_mux();
        cpu_memwrite = 1'b1; cpu_adr = 32'h54; cpu_writedata = 32'd7; mem_rd = $urandom;
        #1;
        checks++;
        if (if_big.mem_we !== 1'b1 || if_big.mem_adr !== 32'h54 || if_big.mem_wd !== 32'd7)
        begin errors++;
            $display("FAIL run_mux: we=%0b adr=%0h wd=%0h want 1/54/7",
                     if_big.mem_we, if_big.mem_adr, if_big.mem_wd); end
        checks++; if (if_big.cpu_readdata !== mem_rd) begin errors++;
            $display("FAIL run_readdata: got %0h want %0h", if_big.cpu_readdata, mem_rd); end
        cpu_memwrite = 1'b0; cpu_adr = $urandom; cpu_writedata = $urandom;
        #1;
        checks++;
        if (if_small.mem_we !== 1'b0 || if_small.mem_adr !== cpu_adr ||
            if_small.mem_wd !== cpu_writedata) begin errors++;
            $display("FAIL run_mux_rd: we=%0b adr=%0h wd=%0h want 0/%0h/%0h", if_small.mem_we,
                     if_small.mem_adr, if_small.mem_wd, cpu_adr, cpu_writedata); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cpu_memwrite = 1'b1; cpu_adr = 32'h54; cpu_writedata = 32'd7; mem_rd = $urandom;
        #1;
        checks++;
        if (if_big.mem_we !== 1'b0 || if_big.mem_adr !== 32'd0 || if_big.cpu_readdata !== mem_rd)
        begin errors++;
            $display("FAIL hold_mux: we=%0b adr=%0h rd=%0h want 0/0/%0h", if_big.mem_we,
                     if_big.mem_adr, if_big.cpu_readdata, mem_rd); end
        cpu_memwrite = 1'b0;
        step();
    endtask

    task automatic test_live_reload();
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load();
        step();
        step();
        clear_logs();
        img = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        pulse_start();
        checks++; if (if_big.cpu_reset !== 1'b1 || if_big.ld_ready !== 1'b1) begin errors++;
            $display("FAIL reload_enter: cpu_reset=%0b ready=%0b want 1/1",
                     if_big.cpu_reset, if_big.ld_ready); end
        send_bytes(4, 1'b1);
        wait_done();
        step();
        checks++;
        if (big_adr.size() != 1 || big_adr[0] !== 32'h0 ||
            big_wd[0] !== {img[0], img[1], img[2], img[3]}) begin errors++;
            $display("FAIL reload_write: count=%0d want 1 word %0h at 0", big_adr.size(),
                     {img[0], img[1], img[2], img[3]}); end
        checks++; if (big_done != 1 || if_big.cpu_reset !== 1'b0) begin errors++;
            $display("FAIL reload_done: pulses=%0d cpu_reset=%0b want 1/0",
                     big_done, if_big.cpu_reset); end
    endtask

    task automatic test_reset_midword();
        pulse_start();
        clear_logs();
        img = '{8'hDE, 8'hAD, 8'hBE};
        send_bytes(3, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (if_big.cpu_reset !== 1'b1 || if_big.ld_ready !== 1'b0 || if_big.mem_we !== 1'b0)
        begin errors++;
            $display("FAIL midword_reset: cpu_reset=%0b ready=%0b we=%0b want 1/0/0",
                     if_big.cpu_reset, if_big.ld_ready, if_big.mem_we); end
        repeat (4) step();
        checks++; if (big_adr.size() != 0 || big_done != 0) begin errors++;
            $display("FAIL midword_nowrite: writes=%0d done=%0d want 0/0",
                     big_adr.size(), big_done); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_image();
        test_partial_word();
        test_overflow();
        test_random_images();
        test_run_mux();
        test_live_reload();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
